// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller for the synchronous FIFO storage array.
//
// Owns the read pointer. Drives a one-hot read select into storage. Captures the
// selected word into a registered output stage and presents it over a valid/ready
// handshake. Empty and level come from the write pointer published by the write side.
// Pointer overrun (level > DEPTH) raises a sticky error flag.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   wr_ptr     in   write pointer (binary, MSB = wrap bit)
//   mem_rdata  in   storage read data, combinational from rd_sel
//   rd_sel     out  one-hot read select, all zero when empty
//   rd_ptr     out  registered read pointer (MSB = wrap bit)
//   empty      out  no unread entry in storage
//   out_data   out  registered output word
//   out_valid  out  out_data holds an unaccepted word
//   out_ready  in   consumer accepts out_data this cycle
//   rd_level   out  (FIFO_RD_LEVEL_EN only) registered unread count incl. output stage
//   ovf_err    out  sticky pointer-overrun flag
//
// Optional feature macro: FIFO_RD_LEVEL_EN

module fifo_read_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW:0]      wr_ptr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [DEPTH-1:0] rd_sel,
  output logic [AW:0]      rd_ptr,
  output logic             empty,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef FIFO_RD_LEVEL_EN
  output logic [AW:0]      rd_level,
`endif
  output logic             ovf_err
);

  typedef enum logic [1:0] {StIdle, StHold, StHoldPend} state_e;

  localparam logic [AW:0] DepthLvl = (AW+1)'(DEPTH);

  state_e      state;
  logic [AW:0] level;
  logic [AW:0] rd_ptr_inc;
  logic [AW:0] rd_ptr_nxt;
  logic        load;
  logic        accept;
  logic        empty_after;

  // Modular subtraction handles wrap via the extra MSB.
  assign level      = wr_ptr - rd_ptr;
  assign empty      = (level == '0);
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign load       = !empty && (!out_valid || out_ready);
  assign accept     = out_valid && out_ready;
  assign rd_ptr_nxt = load ? rd_ptr_inc : rd_ptr;
  // Storage emptiness as seen after this edge, assuming wr_ptr holds.
  assign empty_after = (wr_ptr == rd_ptr_nxt);

  always_comb begin
    rd_sel = '0;
    if (!empty) begin
      rd_sel = {{(DEPTH-1){1'b0}}, 1'b1} << rd_ptr[AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      rd_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= mem_rdata;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr_inc;
      end else if (accept) begin
        out_valid <= 1'b0;
      end

      if (level > DepthLvl) begin
        ovf_err <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (load) begin
            state <= empty_after ? StHold : StHoldPend;
          end
        end
        StHold, StHoldPend: begin
          if (accept && !load) begin
            state <= StIdle;
          end else begin
            state <= empty_after ? StHold : StHoldPend;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  // Counts words still in storage plus the one parked in the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_level <= '0;
    end else begin
      rd_level <= level + {{AW{1'b0}}, out_valid};
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: directed vectors, data checked through a scoreboard queue.

module tb_fifo_read_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned AW    = 2;

  logic             clk;
  logic             rst_n;
  logic [AW:0]      wr_ptr;
  logic [WIDTH-1:0] mem_rdata;
  logic [DEPTH-1:0] rd_sel;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             ovf_err;
`ifdef FIFO_RD_LEVEL_EN
  logic [AW:0]      rd_level;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_q[$];
  int               n_checks;
  int               n_fail;

  fifo_read_ctrl #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_ptr   (wr_ptr),
    .mem_rdata(mem_rdata),
    .rd_sel   (rd_sel),
    .rd_ptr   (rd_ptr),
    .empty    (empty),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef FIFO_RD_LEVEL_EN
    .rd_level (rd_level),
`endif
    .ovf_err  (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage model: read data selected by the one-hot rd_sel.
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_sel[i]) mem_rdata = mem[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL handshake: got %0h, expected no word at %0t", out_data, $time);
      end else begin
        check("handshake_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    wr_ptr    = '0;
    out_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // 1. reset / idle
    do_reset();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rd_sel", 32'(rd_sel), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);

    // 2. single word, consumer stalled
    mem[0] = 4'hA;
    exp_q.push_back(4'hA);
    wr_ptr = 3'd1;
    tick();
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_data", 32'(out_data), 32'hA);
    check("t2_rd_ptr", 32'(rd_ptr), 32'd1);
    check("t2_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_data", 32'(out_data), 32'hA);
      check("t2_hold_valid", 32'(out_valid), 32'd1);
`ifdef FIFO_RD_LEVEL_EN
      check("t2_rd_level", 32'(rd_level), 32'd1);
`endif
    end
    out_ready = 1'b1;
    tick();
    check("t2_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // 3. full storage drained back-to-back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem[i] = 4'(i + 1);
      exp_q.push_back(4'(i + 1));
    end
    out_ready = 1'b1;
    wr_ptr    = 3'd4;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_rd_sel", 32'(rd_sel), 32'(1 << i));
      tick();
      check("t3_data", 32'(out_data), 32'(i + 1));
    end
    check("t3_rd_ptr", 32'(rd_ptr), 32'b100);
    check("t3_rd_sel_end", 32'(rd_sel), 32'h0);
    tick();
    check("t3_valid_end", 32'(out_valid), 32'd0);

    // 4. wrap: advance rd_ptr to 3, then pop across the wrap
    do_reset();
    mem[0] = 4'h5;
    mem[1] = 4'h6;
    mem[2] = 4'h7;
    exp_q.push_back(4'h5);
    exp_q.push_back(4'h6);
    exp_q.push_back(4'h7);
    out_ready = 1'b1;
    wr_ptr    = 3'd3;
    repeat (4) tick();
    check("t4_pre_rd_ptr", 32'(rd_ptr), 32'b011);
    check("t4_pre_valid", 32'(out_valid), 32'd0);
    mem[3] = 4'hC;
    mem[0] = 4'hD;
    exp_q.push_back(4'hC);
    exp_q.push_back(4'hD);
    wr_ptr = 3'b101;
    #1;
    check("t4_rd_sel0", 32'(rd_sel), 32'b1000);
    tick();
    check("t4_rd_ptr1", 32'(rd_ptr), 32'b100);
    check("t4_rd_sel1", 32'(rd_sel), 32'b0001);
    check("t4_data1", 32'(out_data), 32'hC);
    tick();
    check("t4_rd_ptr2", 32'(rd_ptr), 32'b101);
    check("t4_rd_sel2", 32'(rd_sel), 32'b0000);
    check("t4_data2", 32'(out_data), 32'hD);
    tick();
    check("t4_valid_end", 32'(out_valid), 32'd0);

    // 5. overrun is sticky
    do_reset();
    mem[0] = 4'h9;
    exp_q.push_back(4'h9);
    wr_ptr = 3'd5;
    #1;
    check("t5_ovf_before", 32'(ovf_err), 32'd0);
    tick();
    check("t5_ovf_set", 32'(ovf_err), 32'd1);
    check("t5_read_on", 32'(out_data), 32'h9);
    wr_ptr = 3'd1;
    tick();
    check("t5_ovf_sticky", 32'(ovf_err), 32'd1);
    check("t5_valid", 32'(out_valid), 32'd1);

    // 6. asynchronous reset mid-cycle discards the held word
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_rd_ptr", 32'(rd_ptr), 32'd0);
    check("t6_ovf", 32'(ovf_err), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    check("t6_rd_level", 32'(rd_level), 32'd0);
`endif
    exp_q.delete();
    wr_ptr = '0;
    tick();
    rst_n = 1'b1;
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side controller for the team's synchronous FIFO storage: the reader end of the write/read-select interface into the storage array. Owns the read pointer and drives the one-hot read select into storage. Captures the selected word into a registered output stage and hands it to the consumer over a valid/ready handshake. Derives empty and level from the write pointer published by the write side, and flags pointer overrun.

Parameters:
DEPTH, 4, number of storage entries; power of 2, at least 2
WIDTH, 4, data word width
AW, 2, log2(DEPTH); pointers are AW+1 bits (MSB = wrap bit)

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
wr_ptr  in  AW+1  write pointer from write controller, binary with wrap bit
mem_rdata  in  WIDTH  storage read data; combinational function of rd_sel, same cycle
rd_sel  out  DEPTH  one-hot read select into storage; all zero when empty
rd_ptr  out  AW+1  registered read pointer, returned to the write side for its full calculation
empty  out  1  storage holds no unread entry (wr_ptr == rd_ptr)
out_data  out  WIDTH  registered output word
out_valid  out  1  out_data holds a word not yet accepted
out_ready  in  1  consumer accepts out_data this cycle when out_valid=1
ovf_err  out  1  sticky: pointer difference exceeded DEPTH

Behaviour:
- Reset (async assert, sync release on clk): rd_ptr=0, out_valid=0, out_data=0, ovf_err=0; state IDLE. Reset mid-transfer discards out_data. No pop is lost from storage because rd_ptr also returns to 0. The write side resets together with this block.
- level = (wr_ptr - rd_ptr) mod 2^(AW+1). empty = (level==0), combinational.
- rd_sel = one-hot decode of rd_ptr[AW-1:0] when !empty; otherwise all zero.
- load = !empty && (!out_valid || out_ready).
- On load at posedge: out_data <= mem_rdata; out_valid <= 1; rd_ptr <= rd_ptr+1. Wrap from DEPTH-1 to 0 toggles the MSB.
- If out_valid && out_ready && !load: out_valid <= 0; out_data holds its value.
- Accept and load in the same cycle: the new word replaces the old one and out_valid stays 1. This gives back-to-back throughput of one word per clock.
- Latency: the word whose write advances wr_ptr at edge t sets out_valid at edge t+1, if the output stage is free.
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1, storage empty.
  - HOLD_PEND: out_valid=1, storage non-empty.
- Transitions:
  - IDLE -> HOLD or HOLD_PEND on load.
  - HOLD -> IDLE on accept.
  - HOLD_PEND -> HOLD or HOLD_PEND on accept with load.
  - HOLD and HOLD_PEND follow !empty when not accepted.
- out_data is stable while out_valid && !out_ready.
- ovf_err: set at the edge where level > DEPTH. Cleared only by reset. Reads continue unaffected.
- wr_ptr is sampled synchronously. No CDC logic; the block is same-clock only.

Optional Feature:
Macro: FIFO_RD_LEVEL_EN
- Defined: adds output rd_level [AW+1 wide], which counts unread words including the output stage. rd_level = level + out_valid, registered and updated every cycle. Reset value is 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle with wr_ptr=0 -> empty=1, rd_sel=0000, out_valid=0, rd_ptr=0, ovf_err=0.
2. wr_ptr steps 0->1 with mem_rdata=4'hA and out_ready=0 -> next edge out_valid=1, out_data=A, rd_ptr=1, empty=1. Hold 3 cycles -> out_data stays A.
3. wr_ptr=4 (full), out_ready=1 continuously, storage words 1,2,3,4 -> out_data 1,2,3,4 on consecutive edges. rd_ptr reaches 4 with the MSB set. rd_sel sequence 0001,0010,0100,1000 then 0000.
4. Wrap: rd_ptr=3'b011, wr_ptr=3'b101 -> two pops. rd_ptr goes to 3'b100 then 3'b101, with rd_sel 1000 then 0001.
5. Overrun: rd_ptr=0, force wr_ptr=5 -> ovf_err=1 next edge. It remains 1 after wr_ptr returns legal; it clears only on rst_n=0.
6. Assert rst_n=0 asynchronously mid-stream with out_valid=1 -> out_valid=0 and rd_ptr=0 immediately, without waiting for a clk edge. With FIFO_RD_LEVEL_EN, rd_level=0.
